// File: rtl/sfixed_pkg.sv
// -----------------------------------------------------------------------------
// sfixed_pkg
// Shared helpers for the signed fixed-point datapath.
//   qwidth()     : total width of a Q-format (sign + integer + fraction bits).
//   sat_resize() : clamps a wide signed value into a narrower two's-complement
//                  range and reports whether clamping occurred.
// -----------------------------------------------------------------------------
package sfixed_pkg;

  // Widest intermediate value the saturation helper can accept.
  localparam int SFX_MAX_W = 128;

  typedef struct packed {
    logic [SFX_MAX_W-1:0] value;  // in-range value; caller keeps the low bits
    logic                 ovf;    // 1 when the input had to be clamped
  } sat_t;

  function automatic int qwidth(input int int_bits, input int frac_bits);
    return 1 + int_bits + frac_bits;
  endfunction

  // Clamp v into [-2^(w-1), 2^(w-1)-1]. The returned value is still
  // SFX_MAX_W wide, but it is guaranteed to fit in w bits.
  function automatic sat_t sat_resize(input logic signed [SFX_MAX_W-1:0] v,
                                      input int                         w);
    logic signed [SFX_MAX_W-1:0] hi;
    logic signed [SFX_MAX_W-1:0] lo;
    sat_t                        r;
    hi = $signed(({{(SFX_MAX_W-1){1'b0}}, 1'b1} << (w - 1)) - 1'b1);
    lo = ~hi;  // -(2^(w-1)), since ~x == -x-1
    if (v > hi) begin
      r.value = hi;
      r.ovf   = 1'b1;
    end else if (v < lo) begin
      r.value = lo;
      r.ovf   = 1'b1;
    end else begin
      r.value = v;
      r.ovf   = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/sfixed_mult_core_sat.sv
// -----------------------------------------------------------------------------
// sfixed_sat
// Combinational saturating resize from an aligned wide product to the
// output Q-format width.
// Ports:
//   val_i  in  WI  aligned signed value
//   res_o  out WO  saturated / truncated result
//   ovf_o  out 1   result was clamped
// -----------------------------------------------------------------------------
module sfixed_sat
  import sfixed_pkg::*;
#(
  parameter int WI = 17,
  parameter int WO = 8
) (
  input  logic signed [WI-1:0] val_i,
  output logic signed [WO-1:0] res_o,
  output logic                 ovf_o
);

  if (WI > SFX_MAX_W) begin : g_bad_wi
    $error("sfixed_sat: input width %0d exceeds SFX_MAX_W", WI);
  end

  sat_t sat;

  always_comb begin
    sat = sat_resize(SFX_MAX_W'(val_i), WO);
  end

  // Once clamped, the value fits in WO bits, so dropping the upper bits
  // is exact.
  assign res_o = WO'(sat.value);
  assign ovf_o = sat.ovf;

endmodule

// File: rtl/sfixed_mult_core.sv
// -----------------------------------------------------------------------------
// sfixed_mult_core
// Signed fixed-point multiplier with one registered output stage.
// Computes a*b exactly, realigns it to Q(OUT_INT).(OUT_FRAC), then
// saturates it to that format.
//
// Optional feature (macro SFIXED_ROUND_EN): when the product is right
// shifted, add half an output LSB first (round half toward +inf) instead
// of flooring.
//
// Ports:
//   clk        in  1   rising-edge clock
//   rst_n      in  1   synchronous active-low reset
//   in_valid   in  1   operands valid this cycle
//   a          in  WA  signed operand a, Q(A_INT).(A_FRAC)
//   b          in  WB  signed operand b, Q(B_INT).(B_FRAC)
//   out_valid  out 1   result valid (one cycle after in_valid)
//   out        out WO  signed result, Q(OUT_INT).(OUT_FRAC)
//   ovf        out 1   result was saturated
// -----------------------------------------------------------------------------
module sfixed_mult_core
  import sfixed_pkg::*;
#(
  parameter int A_INT    = 7,
  parameter int A_FRAC   = 0,
  parameter int B_INT    = 0,
  parameter int B_FRAC   = 7,
  parameter int OUT_INT  = 7,
  parameter int OUT_FRAC = 0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  input  logic signed [A_INT+A_FRAC:0]     a,
  input  logic signed [B_INT+B_FRAC:0]     b,
  output logic                             out_valid,
  output logic signed [OUT_INT+OUT_FRAC:0] out,
  output logic                             ovf
);

  localparam int WA  = qwidth(A_INT, A_FRAC);
  localparam int WB  = qwidth(B_INT, B_FRAC);
  localparam int WO  = qwidth(OUT_INT, OUT_FRAC);
  localparam int WP  = WA + WB;
  localparam int S   = A_FRAC + B_FRAC - OUT_FRAC;
  localparam int SHR = (S > 0) ? S : 0;
  localparam int SHL = (S < 0) ? -S : 0;
  // One guard bit keeps the rounding add from wrapping; SHL extra bits
  // keep a left shift lossless before saturation.
  localparam int WAL = WP + 1 + SHL;

  if (A_INT < 0 || A_FRAC < 0 || B_INT < 0 || B_FRAC < 0 ||
      OUT_INT < 0 || OUT_FRAC < 0) begin : g_bad_param
    $error("sfixed_mult_core: INT/FRAC parameters must be >= 0");
  end
  if (WA < 2 || WB < 2 || WO < 2) begin : g_bad_width
    $error("sfixed_mult_core: WA, WB and WO must all be >= 2");
  end

  // ---------------------------------------------------------------------------
  // Exact product and alignment
  // ---------------------------------------------------------------------------
  logic signed [WP-1:0]  prod;
  logic signed [WAL-1:0] prod_ext;
  logic signed [WAL-1:0] aligned;

  // WP = WA+WB bits hold any signed product exactly.
  assign prod     = a * b;
  assign prod_ext = {{(WAL - WP){prod[WP-1]}}, prod};

  if (SHR > 0) begin : g_shr
`ifdef SFIXED_ROUND_EN
    localparam logic signed [WAL-1:0] HALF_LSB = {{(WAL-1){1'b0}}, 1'b1} << (SHR - 1);
    assign aligned = (prod_ext + HALF_LSB) >>> SHR;
`else
    assign aligned = prod_ext >>> SHR;
`endif
  end else if (SHL > 0) begin : g_shl
    assign aligned = prod_ext <<< SHL;
  end else begin : g_noshift
    assign aligned = prod_ext;
  end

  // ---------------------------------------------------------------------------
  // Saturation
  // ---------------------------------------------------------------------------
  logic signed [WO-1:0] sat_res;
  logic                 sat_ovf;

  sfixed_sat #(
    .WI (WAL),
    .WO (WO)
  ) u_sat (
    .val_i (aligned),
    .res_o (sat_res),
    .ovf_o (sat_ovf)
  );

  // ---------------------------------------------------------------------------
  // Output register: out/ovf only load on a valid operation, otherwise hold.
  // ---------------------------------------------------------------------------
  logic                 valid_q, valid_d;
  logic signed [WO-1:0] out_q, out_d;
  logic                 ovf_q, ovf_d;

  always_comb begin
    valid_d = in_valid;
    out_d   = out_q;
    ovf_d   = ovf_q;
    if (in_valid) begin
      out_d = sat_res;
      ovf_d = sat_ovf;
    end
  end

  // NOTE: state updates use non-blocking assignments so every register
  // samples its next-state value from the same clock edge; reset is checked
  // first so it overrides a same-cycle in_valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      out_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      out_q   <= out_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_valid = valid_q;
  assign out       = out_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_sfixed_mult_core.sv
// -----------------------------------------------------------------------------
// tb_sfixed_mult_core
// Self-checking bench for sfixed_mult_core with default parameters
// (Q7.0 x Q0.7 -> Q7.0). Expected results come from an integer reference
// model and are queued when stimulus is driven, then popped and compared
// when the DUT presents out_valid. Honours SFIXED_ROUND_EN.
// -----------------------------------------------------------------------------
module tb_sfixed_mult_core;

  typedef struct {
    int   res;
    logic ovf;
  } exp_t;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic signed [7:0] a;
  logic signed [7:0] b;
  logic              out_valid;
  logic signed [7:0] dut_out;
  logic              ovf;

  int   n_checks = 0;
  int   n_fails  = 0;
  exp_t sb_q[$];
  int   last_res = 0;
  logic last_ovf = 1'b0;

  sfixed_mult_core dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out       (dut_out),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference: exact product of Q7.0 and Q0.7, scaled by 2^-7, then clamped.
  function automatic exp_t model(input int av, input int bv);
    longint p;
    exp_t   e;
    p = longint'(av) * longint'(bv);
`ifdef SFIXED_ROUND_EN
    p = p + 64;
`endif
    p = p >>> 7;
    if (p > 127) begin
      e.res = 127;
      e.ovf = 1'b1;
    end else if (p < -128) begin
      e.res = -128;
      e.ovf = 1'b1;
    end else begin
      e.res = int'(p);
      e.ovf = 1'b0;
    end
    return e;
  endfunction

  // Drive one cycle of stimulus, clock it, and check the registered outputs.
  task automatic step(input logic rst_v, input logic v, input int av, input int bv);
    exp_t e;
    rst_n    = rst_v;
    in_valid = v;
    a        = 8'(av);
    b        = 8'(bv);
    if (rst_v && v) sb_q.push_back(model(av, bv));
    @(posedge clk);
    #1;
    if (!rst_v) begin
      sb_q.delete();
      last_res = 0;
      last_ovf = 1'b0;
      check("reset_valid", out_valid, 0);
      check("reset_out", dut_out, 0);
      check("reset_ovf", ovf, 0);
    end else if (v) begin
      check("out_valid", out_valid, 1);
      if (sb_q.size() == 0) begin
        check("sb_underflow", 0, 1);
      end else begin
        e = sb_q.pop_front();
        check($sformatf("out a=%0d b=%0d", av, bv), dut_out, e.res);
        check($sformatf("ovf a=%0d b=%0d", av, bv), ovf, e.ovf);
        last_res = e.res;
        last_ovf = e.ovf;
      end
    end else begin
      check("idle_valid", out_valid, 0);
      check("hold_out", dut_out, last_res);
      check("hold_ovf", ovf, last_ovf);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;

    step(1'b0, 1'b0, 0, 0);
    step(1'b0, 1'b0, 0, 0);

    // Directed cases
    step(1'b1, 1'b1, 100, 8'sh40);   // 50
    step(1'b1, 1'b1, 127, 8'sh7F);   // 126
    step(1'b1, 1'b1, -3, 8'sh40);    // -2 floor, -1 rounded
    step(1'b1, 1'b1, -128, -128);    // +saturation
    step(1'b1, 1'b0, 0, 0);          // hold 127/ovf
    step(1'b1, 1'b0, 55, 66);        // hold, operands ignored

    // Back-to-back stream
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, i * 23 - 60, 127 - i * 40);
    step(1'b1, 1'b0, 0, 0);

    // Reset together with in_valid discards it
    step(1'b1, 1'b1, 100, 8'sh40);
    step(1'b0, 1'b1, 100, 8'sh40);
    step(1'b1, 1'b1, -128, 127);     // first op after release: -127
    step(1'b1, 1'b1, 1, 1);          // tiny product -> 0

    // Random mix of valid and idle cycles
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'($urandom_range(0, 1)),
           int'($signed(8'($urandom))), int'($signed(8'($urandom))));
    end
    step(1'b1, 1'b0, 0, 0);
    check("sb_empty", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/sfixed_mult_core.md
Name:
sfixed_mult_core

Overview:
- Parameterised signed fixed-point multiplier with one registered output stage.
- Multiplies two two's-complement fixed-point operands of independent Q-formats and realigns the product to a third Q-format.
- Out-of-range results saturate and raise an overflow flag.
- Used in the ALU multiply stage (e.g. integer sample × Q0.7 coefficient → integer result).

Parameters:
- A_INT, 7: integer bits of operand a, excluding sign.
- A_FRAC, 0: fractional bits of operand a.
- B_INT, 0: integer bits of operand b, excluding sign.
- B_FRAC, 7: fractional bits of operand b.
- OUT_INT, 7: integer bits of result, excluding sign.
- OUT_FRAC, 0: fractional bits of result.
- Parameter order is fixed as listed, so positional override works.
- Derived widths: WA=1+A_INT+A_FRAC, WB=1+B_INT+B_FRAC, WO=1+OUT_INT+OUT_FRAC.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  operands valid this cycle.
- a  in  WA  signed operand a.
- b  in  WB  signed operand b.
- out_valid  out  1  result valid.
- out  out  WO  signed result.
- ovf  out  1  result was saturated.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rst_n).
- Reset: on a clk edge with rst_n=0, out_valid=0, out=0, ovf=0. Reset wins over in_valid in the same cycle. An operation in flight is discarded.
- Full product:
  - P = a*b, signed, width WA+WB, format Q(A_INT+B_INT+1).(A_FRAC+B_FRAC).
  - P is exact; no intermediate loss.
- Alignment: S = A_FRAC+B_FRAC-OUT_FRAC.
  - S>0: arithmetic right shift by S (floor, toward −inf).
  - S=0: no shift.
  - S<0: left shift by −S, zero fill.
- Saturation:
  - If the aligned value exceeds 2^(WO-1)-1, out = 2^(WO-1)-1 and ovf=1.
  - If it is below −2^(WO-1), out = −2^(WO-1) and ovf=1.
  - Otherwise out = aligned value truncated to WO bits, ovf=0.
- Latency: exactly 1 cycle.
  - When in_valid=1 at edge N, out/ovf are updated at edge N and out_valid=1 after edge N.
  - When in_valid=0, out_valid=0 and out/ovf hold their previous values.
- Throughput: one operation per cycle, no stall, no backpressure.
- Elaboration checks: all INT/FRAC parameters ≥0; WA, WB, WO ≥2. Violations raise an elaboration error ($error).

Optional Feature:
- Macro SFIXED_ROUND_EN.
- Defined: when S>0, add 2^(S-1) to P before the right shift (round half toward +inf). Saturation applies afterwards, and the add must not wrap (widen by 1 bit).
- Undefined: floor truncation as above.
- S≤0 is unaffected in either case.

Decomposition:
- Shared package sfixed_pkg:
  - function for Q-format total width (1+int+frac);
  - saturating-resize function (signed value, target width → value plus overflow bit).
- One natural sub-module, sfixed_sat, is combinational: aligned wide value in, WO result plus ovf out.
- The top level holds the multiplier, shift/round logic and output register.

Test Plan:
All cases use default parameters; "0x40" is 0.5 in Q0.7.
- a=100, b=0x40, in_valid=1 → next cycle out=50, ovf=0, out_valid=1.
- a=127, b=0x7F → out=126, ovf=0.
- a=−3, b=0x40 → out=−2 without SFIXED_ROUND_EN; out=−1 with it.
- a=−128, b=0x80 (−1.0) → out=127, ovf=1 (positive saturation).
- Back-to-back valid inputs every cycle give results one cycle later in order. After in_valid drops, out_valid=0 and out holds its value.
- rst_n=0 asserted together with in_valid=1 → after that edge out_valid=0, out=0, ovf=0. The first valid after reset release is processed normally.
